// File: rtl/ahb2apb_bridge_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for the AHB-to-APB bridge.
//
// ahb_if : AHB-Lite slave-side bundle seen at one HSELx output of the
//          interconnect.
//    master modport : decoder/master view (drives the address/data phase)
//    slave  modport : bridge view (returns HREADY_O / HRESP / HRDATA)
//    HSEL, HADDR, HTRANS, HWRITE, HSIZE  address phase
//    HWSTRB, HWDATA                      data phase write payload
//    HREADY_I                            bus-wide ready (previous transfer done)
//    HREADY_O, HRESP, HRDATA             this slave's response
//
// apb_if : APB3/APB4 peripheral bus.
//    master modport : bridge view (requester)
//    slave  modport : completer view
//    PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB   request
//    PRDATA, PREADY, PSLVERR                       completion
// ----------------------------------------------------------------------------
interface ahb_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic            HSEL;
   logic [AW-1:0]   HADDR;
   logic [1:0]      HTRANS;
   logic            HWRITE;
   logic [2:0]      HSIZE;
   logic [DW/8-1:0] HWSTRB;
   logic [DW-1:0]   HWDATA;
   logic            HREADY_I;
   logic            HREADY_O;
   logic            HRESP;
   logic [DW-1:0]   HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWSTRB, HWDATA, HREADY_I,
      input  HREADY_O, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWSTRB, HWDATA, HREADY_I,
      output HREADY_O, HRESP, HRDATA
   );
endinterface

interface apb_if #(
   parameter int unsigned PAW = 16,
   parameter int unsigned DW  = 32
);
   logic            PSEL;
   logic            PENABLE;
   logic [PAW-1:0]  PADDR;
   logic            PWRITE;
   logic [DW-1:0]   PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic [DW-1:0]   PRDATA;
   logic            PREADY;
   logic            PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/ahb2apb_bridge.sv
// ----------------------------------------------------------------------------
// ahb2apb_bridge
//   AHB slave that turns each accepted AHB transfer into exactly one APB
//   transfer, holding the AHB data phase with wait states until the APB
//   completer responds. Read data and the OKAY/ERROR response are forwarded.
//   Misaligned or oversized transfers get a two-cycle ERROR response with no
//   APB activity. All outputs are registered.
//
// Ports
//   HCLK     clock
//   HRESETN  asynchronous active-low reset
//   ahb      ahb_if.slave  : HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWSTRB/HWDATA/
//                            HREADY_I in, HREADY_O/HRESP/HRDATA out
//   apb      apb_if.master : PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB out,
//                            PRDATA/PREADY/PSLVERR in
// ----------------------------------------------------------------------------
module ahb2apb_bridge #(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned PAW = 16
) (
   input  logic   HCLK,
   input  logic   HRESETN,
   ahb_if.slave   ahb,
   apb_if.master  apb
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_SETUP,
      S_ACCESS,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t        state;

   logic [31:0]   size_bytes;
   logic [AW-1:0] addr_mask;
   logic          start;
   logic          illegal;

   // Address-phase decode. Only NONSEQ/SEQ start a transfer; IDLE/BUSY and
   // unselected cycles fall through as zero-wait OKAY.
   always_comb begin
      size_bytes = 32'd1 << ahb.HSIZE;
      addr_mask  = AW'(size_bytes - 32'd1);
      start      = ahb.HSEL && ahb.HREADY_I &&
                   ((ahb.HTRANS == 2'b10) || (ahb.HTRANS == 2'b11));
      illegal    = (size_bytes > DW / 8) || ((ahb.HADDR & addr_mask) != '0);
   end

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state        <= S_IDLE;
         ahb.HREADY_O <= 1'b1;
         ahb.HRESP    <= 1'b0;
         ahb.HRDATA   <= '0;
         apb.PSEL     <= 1'b0;
         apb.PENABLE  <= 1'b0;
         apb.PADDR    <= '0;
         apb.PWRITE   <= 1'b0;
         apb.PWDATA   <= '0;
         apb.PSTRB    <= '0;
      end else begin
         case (state)
            // ERR2 is the second (ready) cycle of an ERROR response; it also
            // samples the next address phase exactly like IDLE.
            S_IDLE, S_ERR2: begin
               ahb.HRESP <= 1'b0;
               if (start && illegal) begin
                  state        <= S_ERR1;
                  ahb.HRESP    <= 1'b1;
                  ahb.HREADY_O <= 1'b0;
               end else if (start) begin
                  state        <= S_DATA;
                  ahb.HREADY_O <= 1'b0;
                  apb.PADDR    <= ahb.HADDR[PAW-1:0];
                  apb.PWRITE   <= ahb.HWRITE;
               end else begin
                  state        <= S_IDLE;
                  ahb.HREADY_O <= 1'b1;
               end
            end

            // Write payload is only valid in the AHB data phase.
            S_DATA: begin
               if (apb.PWRITE) begin
                  apb.PWDATA <= ahb.HWDATA;
                  apb.PSTRB  <= ahb.HWSTRB;
               end else begin
                  apb.PSTRB  <= '0;
               end
               apb.PSEL    <= 1'b1;
               apb.PENABLE <= 1'b0;
               state       <= S_SETUP;
            end

            S_SETUP: begin
               apb.PENABLE <= 1'b1;
               state       <= S_ACCESS;
            end

            S_ACCESS: begin
               if (apb.PREADY) begin
                  apb.PSEL    <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  if (apb.PSLVERR) begin
                     ahb.HRESP <= 1'b1;
                     state     <= S_ERR1;
                  end else begin
                     ahb.HREADY_O <= 1'b1;
                     if (!apb.PWRITE) begin
                        ahb.HRDATA <= apb.PRDATA;
                     end
                     state <= S_IDLE;
                  end
               end
            end

            S_ERR1: begin
               ahb.HREADY_O <= 1'b1;
               state        <= S_ERR2;
            end

            default: begin
               state        <= S_IDLE;
               ahb.HREADY_O <= 1'b1;
               ahb.HRESP    <= 1'b0;
               apb.PSEL     <= 1'b0;
               apb.PENABLE  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// ----------------------------------------------------------------------------
// Testbench for ahb2apb_bridge. Directed AHB transfers push their expected
// AHB response and APB transaction into queues; independent monitors pop and
// compare when the DUT completes an AHB data phase or an APB access.
// ----------------------------------------------------------------------------
module tb_ahb2apb_bridge;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ahb_if #(.AW(32), .DW(32)) ahb ();
   apb_if #(.PAW(16), .DW(32)) apb ();

   ahb2apb_bridge #(.AW(32), .DW(32), .PAW(16)) dut (
      .HCLK    (clk),
      .HRESETN (rstn),
      .ahb     (ahb),
      .apb     (apb)
   );

   typedef struct {
      logic        resp;
      logic [31:0] rdata;
      int          waits;
   } ahb_exp_t;

   typedef struct {
      logic [15:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          en_cycles;
   } apb_exp_t;

   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];

   int checks = 0;
   int errors = 0;

   // APB completer model
   int unsigned apb_wait  = 0;
   logic        apb_err   = 1'b0;
   logic [31:0] apb_rdata = '0;
   int unsigned acc_cnt   = 0;

   logic [31:0] model_hrdata = '0;

   assign ahb.HREADY_I = ahb.HREADY_O;
   assign apb.PREADY   = (acc_cnt >= apb_wait);
   assign apb.PSLVERR  = apb_err && apb.PREADY;
   assign apb.PRDATA   = apb_rdata;

   always @(posedge clk) acc_cnt <= (apb.PSEL && apb.PENABLE) ? acc_cnt + 1 : 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // AHB response monitor
   initial begin : ahb_mon
      logic     pending;
      int       waits;
      logic     last_resp;
      ahb_exp_t e;
      pending   = 1'b0;
      waits     = 0;
      last_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pending = 1'b0;
            waits   = 0;
         end else if (ahb.HREADY_O) begin
            if (pending) begin
               if (ahb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ahb_unexpected: got completion expected none");
               end else begin
                  e = ahb_q.pop_front();
                  check32("ahb_hresp", 32'(ahb.HRESP), 32'(e.resp));
                  check32("ahb_hrdata", ahb.HRDATA, e.rdata);
                  check32("ahb_waits", 32'(waits), 32'(e.waits));
                  if (e.waits > 0) check32("ahb_wait_resp", 32'(last_resp), 32'(e.resp));
               end
            end
            pending   = ahb.HSEL;
            waits     = 0;
            last_resp = 1'b0;
         end else if (pending) begin
            waits++;
            last_resp = ahb.HRESP;
         end
      end
   end

   // APB transaction monitor
   initial begin : apb_mon
      logic        setup_seen;
      logic        unstable;
      int          en;
      logic [52:0] snap;
      apb_exp_t    a;
      setup_seen = 1'b0;
      unstable   = 1'b0;
      en         = 0;
      snap       = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            setup_seen = 1'b0;
            en         = 0;
         end else if (apb.PSEL && !apb.PENABLE) begin
            if (apb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL apb_unexpected: got PSEL=1 expected PSEL=0");
            end
            setup_seen = 1'b1;
            unstable   = 1'b0;
            en         = 0;
            snap       = {apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB};
         end else if (apb.PSEL && apb.PENABLE) begin
            en++;
            if ({apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB} !== snap) unstable = 1'b1;
            if (apb.PREADY) begin
               check32("apb_setup_phase", 32'(setup_seen), 32'd1);
               check32("apb_stable", 32'(unstable), 32'd0);
               if (apb_q.size() != 0) begin
                  a = apb_q.pop_front();
                  check32("apb_paddr", 32'(apb.PADDR), 32'(a.addr));
                  check32("apb_pwrite", 32'(apb.PWRITE), 32'(a.write));
                  check32("apb_pstrb", 32'(apb.PSTRB), 32'(a.strb));
                  check32("apb_penable_cycles", 32'(en), 32'(a.en_cycles));
                  if (a.write) check32("apb_pwdata", apb.PWDATA, a.wdata);
               end
               setup_seen = 1'b0;
            end
         end
      end
   end

   // Issue one AHB transfer; returns #1 after its accept edge with the data
   // phase driven and HSEL released (a following issue() pipelines onto it).
   task automatic issue(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                        input logic exp_resp, input int exp_waits, input int exp_en);
      ahb_exp_t e;
      apb_exp_t a;
      int       n;
      if (exp_en > 0) begin
         a.addr      = addr[15:0];
         a.write     = wr;
         a.wdata     = wdata;
         a.strb      = wr ? strb : 4'h0;
         a.en_cycles = exp_en;
         apb_q.push_back(a);
         if (!wr && !exp_resp) model_hrdata = apb_rdata;
      end
      e.resp  = exp_resp;
      e.rdata = model_hrdata;
      e.waits = exp_waits;
      ahb_q.push_back(e);
      ahb.HSEL   = 1'b1;
      ahb.HADDR  = addr;
      ahb.HTRANS = trans;
      ahb.HWRITE = wr;
      ahb.HSIZE  = size;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ahb.HREADY_O && n < 200);
      if (!ahb.HREADY_O) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got HREADY_O=0 expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
      ahb.HWDATA = wdata;
      ahb.HWSTRB = strb;
      ahb.HSEL   = 1'b0;
      ahb.HTRANS = 2'b00;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((ahb_q.size() != 0 || apb_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check32("drain_outstanding", 32'(ahb_q.size() + apb_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      ahb.HSEL   = 1'b0;
      ahb.HADDR  = '0;
      ahb.HTRANS = 2'b00;
      ahb.HWRITE = 1'b0;
      ahb.HSIZE  = 3'd0;
      ahb.HWSTRB = '0;
      ahb.HWDATA = '0;
      repeat (3) @(posedge clk);
      #1;
      check32("rst_hready_o", 32'(ahb.HREADY_O), 32'd1);
      check32("rst_hresp", 32'(ahb.HRESP), 32'd0);
      check32("rst_hrdata", ahb.HRDATA, 32'd0);
      check32("rst_psel", 32'(apb.PSEL), 32'd0);
      check32("rst_penable", 32'(apb.PENABLE), 32'd0);
      check32("rst_paddr", 32'(apb.PADDR), 32'd0);
      check32("rst_pwrite", 32'(apb.PWRITE), 32'd0);
      check32("rst_pwdata", apb.PWDATA, 32'd0);
      check32("rst_pstrb", 32'(apb.PSTRB), 32'd0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Word write, PREADY tied high: 3 wait states
      issue(2'b10, 32'h0000_1234, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF, 1'b0, 3, 1);
      wait_idle();

      // Read with 4 PREADY-low cycles: PENABLE 5 cycles, 7 wait states
      apb_wait  = 4;
      apb_rdata = 32'hA5A5_0001;
      issue(2'b10, 32'h0000_0010, 1'b0, 3'd2, 32'h0, 4'hF, 1'b0, 7, 5);
      wait_idle();

      // Read with PSLVERR: 3 waits + ERR1, HRDATA unchanged
      apb_wait  = 0;
      apb_err   = 1'b1;
      apb_rdata = 32'h0BAD_0BAD;
      issue(2'b10, 32'h0000_0020, 1'b0, 3'd2, 32'h0, 4'h0, 1'b1, 4, 1);
      wait_idle();
      apb_err = 1'b0;

      // Unaligned word: ERROR, no APB
      issue(2'b10, 32'h0000_0002, 1'b1, 3'd2, 32'h1111_1111, 4'hF, 1'b1, 1, 0);
      wait_idle();

      // Back-to-back write/read, then IDLE and BUSY zero-wait OKAYs
      apb_rdata = 32'h0BAD_F00D;
      issue(2'b10, 32'h0000_0100, 1'b1, 3'd1, 32'h1122_3344, 4'b0011, 1'b0, 3, 1);
      issue(2'b10, 32'h0000_0104, 1'b0, 3'd2, 32'h0, 4'hF, 1'b0, 3, 1);
      issue(2'b00, 32'h0000_0200, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0, 0, 0);
      issue(2'b01, 32'h0000_0204, 1'b1, 3'd2, 32'h0, 4'h0, 1'b0, 0, 0);
      wait_idle();

      // Oversized transfer, next transfer accepted during ERR2
      issue(2'b10, 32'h0000_0000, 1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 1, 0);
      issue(2'b11, 32'h0001_0008, 1'b1, 3'd2, 32'h7777_8888, 4'hC, 1'b0, 3, 1);
      wait_idle();

      // Reset during ACCESS with PREADY held low
      apb_wait = 1000;
      issue(2'b10, 32'h0000_0040, 1'b1, 3'd2, 32'h5555_5555, 4'hF, 1'b0, 3, 1);
      n = 0;
      while (!apb.PENABLE && n < 50) begin
         @(negedge clk);
         n++;
      end
      check32("reach_access", 32'(apb.PENABLE), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check32("arst_psel", 32'(apb.PSEL), 32'd0);
      check32("arst_penable", 32'(apb.PENABLE), 32'd0);
      check32("arst_hready_o", 32'(ahb.HREADY_O), 32'd1);
      check32("arst_hresp", 32'(ahb.HRESP), 32'd0);
      ahb_q.delete();
      apb_q.delete();
      model_hrdata = '0;
      apb_wait     = 0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      issue(2'b10, 32'h0000_0044, 1'b1, 3'd2, 32'hCAFE_F00D, 4'hF, 1'b0, 3, 1);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
